// File: rtl/morse_pkg.sv
// Shared constants and types for the Morse decoder counter blocks.
// Holds the counting-mode and direction encodings, the default element
// modulus, and the action encoding that the counter core decodes each cycle.
package morse_pkg;

  // Counting mode at the ends of the range.
  localparam int CNT_WRAP = 0;  // roll over to the opposite end
  localparam int CNT_SAT  = 1;  // hold at the end and flag overflow

  // Default modulus: elements per Morse symbol.
  localparam int MODULUS_ELEM = 5;

  // Count direction, matching the polarity of the up_dn pin.
  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  // What the counter does on the coming clock edge. Priority is resolved
  // before this is chosen, so exactly one action applies per cycle.
  typedef enum logic [2:0] {
    ACT_HOLD  = 3'd0,  // nothing requested
    ACT_CLEAR = 3'd1,  // synchronous clear
    ACT_LOAD  = 3'd2,  // parallel load (clamped to the range)
    ACT_INC   = 3'd3,  // step up inside the range
    ACT_DEC   = 3'd4,  // step down inside the range
    ACT_WRAP  = 3'd5,  // step past an end, roll to the other end
    ACT_BLOCK = 3'd6   // step past an end, held by saturation
  } cnt_act_e;

endpackage : morse_pkg

// File: rtl/step_sync_edge.sv
// Synchroniser plus rising-edge detector for a slow asynchronous level
// (switch or button). Produces a single-cycle pulse per low-to-high
// transition seen after synchronisation.
//
// Every flop resets to 1, so an input that is already high when reset is
// released looks like "no change" and produces no pulse; the input has to
// drop and rise again before the first pulse appears.
//
// Latency: a rise captured by the first stage at edge k shows up on
// pulse_out during the cycle after edge k+SYNC_STAGES-1, so a consumer
// registering on it updates at edge k+SYNC_STAGES.
module step_sync_edge
  import morse_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic reset,
  input  logic async_in,
  output logic pulse_out
);

  // Synchroniser chain: bit 0 is the first (metastability-exposed) stage,
  // the top bit is the settled copy used by the edge detector.
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  // History of the settled copy, one cycle old.
  logic prev_q;
  logic prev_d;

  // Shift the raw input into the chain and remember the last settled value.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // Synchroniser and history registers, all-ones after reset.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  // Rising edge of the settled copy.
  always_comb begin
    pulse_out = sync_q[SYNC_STAGES-1] & ~prev_q;
  end

endmodule : step_sync_edge

// File: rtl/mod_n_step_counter.sv
// Parametrised modulo-N step counter for the Morse decoder datapath.
//
// A raw step level is synchronised and edge-detected; each detected rise
// moves the count one place up or down inside 0..MODULUS-1. At the ends the
// count either wraps (pulsing wrap) or holds (pulsing ovf), chosen by
// SATURATE. Clear and parallel load take precedence over a step, and a step
// that collides with either is dropped rather than queued.
//
// tc is combinational so a direction change is reflected without waiting
// for a clock edge; everything else is registered.
module mod_n_step_counter
  import morse_pkg::*;
#(
  parameter int MODULUS     = MODULUS_ELEM,
  parameter int WIDTH       = 3,
  parameter int SATURATE    = CNT_WRAP,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             step_raw,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             up_dn,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  // Range ends and the unit step, all held in WIDTH bits.
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] MIN_VAL = '0;
  localparam logic [WIDTH-1:0] ONE_VAL = WIDTH'(1);

  // Resolved once at elaboration so the end-of-range choice is a constant.
  localparam bit HOLD_AT_ENDS = (SATURATE == CNT_SAT);

  // Registered state.
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             wrap_q;
  logic             wrap_d;
  logic             ovf_q;
  logic             ovf_d;

  // Decoded per-cycle inputs.
  logic             step_evt;
  dir_e             dir;
  logic             at_top;
  logic             at_bot;
  logic [WIDTH-1:0] load_clamped;
  cnt_act_e         act;

  // Step input: synchronise the raw level and turn each rise into a pulse.
  step_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_step_sync_edge (
    .CLK      (CLK),
    .reset    (reset),
    .async_in (step_raw),
    .pulse_out(step_evt)
  );

  // Direction and end-of-range status of the current count.
  always_comb begin
    dir    = up_dn ? DIR_UP : DIR_DOWN;
    at_top = (count_q == MAX_VAL);
    at_bot = (count_q == MIN_VAL);
  end

  // Load value forced into range: anything past the top end lands on it.
  always_comb begin
    if (load_val > MAX_VAL) begin
      load_clamped = MAX_VAL;
    end else begin
      load_clamped = load_val;
    end
  end

  // Pick this cycle's action: clear beats load beats a step.
  always_comb begin
    act = ACT_HOLD;
    if (clear) begin
      act = ACT_CLEAR;
    end else if (load) begin
      act = ACT_LOAD;
    end else if (step_evt) begin
      if (dir == DIR_UP) begin
        if (!at_top) begin
          act = ACT_INC;
        end else if (HOLD_AT_ENDS) begin
          act = ACT_BLOCK;
        end else begin
          act = ACT_WRAP;
        end
      end else begin
        if (!at_bot) begin
          act = ACT_DEC;
        end else if (HOLD_AT_ENDS) begin
          act = ACT_BLOCK;
        end else begin
          act = ACT_WRAP;
        end
      end
    end
  end

  // Next count and flag values for the chosen action; flags default low so
  // they only ever last one cycle and can never both be set.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    ovf_d   = 1'b0;
    case (act)
      ACT_CLEAR: count_d = MIN_VAL;
      ACT_LOAD:  count_d = load_clamped;
      ACT_INC:   count_d = count_q + ONE_VAL;
      ACT_DEC:   count_d = count_q - ONE_VAL;
      ACT_WRAP: begin
        count_d = (dir == DIR_UP) ? MIN_VAL : MAX_VAL;
        wrap_d  = 1'b1;
      end
      ACT_BLOCK: ovf_d = 1'b1;
      default:   count_d = count_q;
    endcase
  end

  // Count and flag registers.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      count_q <= MIN_VAL;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
    end
  end

  // Outputs: registered state plus the combinational terminal count, which
  // watches whichever end the current direction is heading towards.
  always_comb begin
    count = count_q;
    wrap  = wrap_q;
    ovf   = ovf_q;
    tc    = (dir == DIR_UP) ? at_top : at_bot;
  end

endmodule : mod_n_step_counter

// File: tb/tb_mod_n_step_counter.sv
// Testbench for mod_n_step_counter. Three instances share one stimulus
// stream: MODULUS=5 wrapping, MODULUS=5 saturating, MODULUS=10 wrapping.
// A reference model predicts every cycle's state into a queue; a monitor
// on the falling edge pops and compares. A few directed spot checks use
// constants worked out by hand.
module tb_mod_n_step_counter;

  localparam int SYNC = 2;

  logic       CLK      = 1'b0;
  logic       reset    = 1'b1;
  logic       step_raw = 1'b1;
  logic       clear    = 1'b0;
  logic       load     = 1'b0;
  logic       up_dn    = 1'b1;
  logic [3:0] lv4      = 4'd0;

  logic [2:0] cnt_w5, cnt_s5;
  logic [3:0] cnt_w10;
  logic tc_w5, tc_s5, tc_w10;
  logic wrap_w5, wrap_s5, wrap_w10;
  logic ovf_w5, ovf_s5, ovf_w10;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  mod_n_step_counter #(.MODULUS(5), .WIDTH(3), .SATURATE(0), .SYNC_STAGES(SYNC)) u_w5 (
    .CLK(CLK), .reset(reset), .step_raw(step_raw), .clear(clear), .load(load),
    .load_val(lv4[2:0]), .up_dn(up_dn), .count(cnt_w5), .tc(tc_w5), .wrap(wrap_w5), .ovf(ovf_w5));

  mod_n_step_counter #(.MODULUS(5), .WIDTH(3), .SATURATE(1), .SYNC_STAGES(SYNC)) u_s5 (
    .CLK(CLK), .reset(reset), .step_raw(step_raw), .clear(clear), .load(load),
    .load_val(lv4[2:0]), .up_dn(up_dn), .count(cnt_s5), .tc(tc_s5), .wrap(wrap_s5), .ovf(ovf_s5));

  mod_n_step_counter #(.MODULUS(10), .WIDTH(4), .SATURATE(0), .SYNC_STAGES(SYNC)) u_w10 (
    .CLK(CLK), .reset(reset), .step_raw(step_raw), .clear(clear), .load(load),
    .load_val(lv4), .up_dn(up_dn), .count(cnt_w10), .tc(tc_w10), .wrap(wrap_w10), .ovf(ovf_w10));

  // ---------------- comparison helper ----------------
  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int mod_of(input int i);
    return (i == 2) ? 10 : 5;
  endfunction
  function automatic bit sat_of(input int i);
    return (i == 1);
  endfunction
  function automatic int mask_of(input int i);
    return (i == 2) ? 15 : 7;
  endfunction

  typedef struct packed {
    logic [3:0] c0;
    logic [3:0] c1;
    logic [3:0] c2;
    logic [2:0] w;
    logic [2:0] o;
  } exp_t;

  exp_t exp_q[$];
  bit   hist[$];   // hist[0] = step_raw seen at the latest edge, older after
  int   mc[3];
  bit   mw[3];
  bit   mo[3];

  function automatic void model_reset();
    hist = {};
    for (int i = 0; i <= SYNC; i++) hist.push_back(1'b1);
    for (int i = 0; i < 3; i++) begin
      mc[i] = 0;
      mw[i] = 1'b0;
      mo[i] = 1'b0;
    end
  endfunction

  function automatic exp_t pack_exp();
    exp_t e;
    e.c0 = 4'(mc[0]);
    e.c1 = 4'(mc[1]);
    e.c2 = 4'(mc[2]);
    for (int i = 0; i < 3; i++) begin
      e.w[i] = mw[i];
      e.o[i] = mo[i];
    end
    return e;
  endfunction

  // A rise of step_raw sampled SYNC edges ago, after a low one edge before it,
  // is the step that acts on this edge.
  always @(posedge CLK or posedge reset) begin
    bit evt;
    int top;
    int lv;
    if (reset) begin
      model_reset();
      exp_q.delete();
      exp_q.push_back(pack_exp());
    end else begin
      evt = hist[SYNC-1] & ~hist[SYNC];
      for (int i = 0; i < 3; i++) begin
        top   = mod_of(i) - 1;
        mw[i] = 1'b0;
        mo[i] = 1'b0;
        if (clear) begin
          mc[i] = 0;
        end else if (load) begin
          lv    = int'(lv4) & mask_of(i);
          mc[i] = (lv > top) ? top : lv;
        end else if (evt) begin
          if (up_dn) begin
            if (mc[i] < top) mc[i] = mc[i] + 1;
            else if (sat_of(i)) mo[i] = 1'b1;
            else begin mc[i] = 0; mw[i] = 1'b1; end
          end else begin
            if (mc[i] > 0) mc[i] = mc[i] - 1;
            else if (sat_of(i)) mo[i] = 1'b1;
            else begin mc[i] = top; mw[i] = 1'b1; end
          end
        end
      end
      hist.push_front(step_raw);
      void'(hist.pop_back());
      exp_q.push_back(pack_exp());
    end
  end

  // ---------------- monitor ----------------
  always @(negedge CLK) begin
    exp_t e;
    int   c;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 0, 1);
    end else begin
      while (exp_q.size() > 1) void'(exp_q.pop_front());
      e = exp_q.pop_front();
      chk("w5_count", int'(cnt_w5), int'(e.c0));
      chk("w5_wrap", int'(wrap_w5), int'(e.w[0]));
      chk("w5_ovf", int'(ovf_w5), int'(e.o[0]));
      c = int'(e.c0);
      chk("w5_tc", int'(tc_w5), up_dn ? int'(c == 4) : int'(c == 0));
      chk("s5_count", int'(cnt_s5), int'(e.c1));
      chk("s5_wrap", int'(wrap_s5), int'(e.w[1]));
      chk("s5_ovf", int'(ovf_s5), int'(e.o[1]));
      c = int'(e.c1);
      chk("s5_tc", int'(tc_s5), up_dn ? int'(c == 4) : int'(c == 0));
      chk("w10_count", int'(cnt_w10), int'(e.c2));
      chk("w10_wrap", int'(wrap_w10), int'(e.w[2]));
      chk("w10_ovf", int'(ovf_w10), int'(e.o[2]));
      c = int'(e.c2);
      chk("w10_tc", int'(tc_w10), up_dn ? int'(c == 9) : int'(c == 0));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic step_pulse(input bit dir);
    up_dn    = dir;
    step_raw = 1'b1;
    repeat (3) tick();
    step_raw = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    // Reset with step_raw already high: no count after release.
    repeat (3) tick();
    reset = 1'b0;
    repeat (20) tick();
    chk("held_high_no_count", int'(cnt_w5), 0);

    // Fresh rise: count moves exactly two edges later.
    step_raw = 1'b0;
    repeat (3) tick();
    step_raw = 1'b1;
    tick();
    tick();
    chk("latency_edge1", int'(cnt_w5), 0);
    tick();
    chk("latency_edge2", int'(cnt_w5), 1);
    step_raw = 1'b0;
    repeat (3) tick();

    // Six up steps from zero.
    clear = 1'b1; tick(); clear = 1'b0;
    repeat (6) step_pulse(1'b1);
    chk("up6_w5", int'(cnt_w5), 1);
    chk("up6_s5", int'(cnt_s5), 4);
    chk("up6_w10", int'(cnt_w10), 6);

    // Two down steps from zero: saturating instance holds at 0.
    clear = 1'b1; tick(); clear = 1'b0;
    repeat (2) step_pulse(1'b0);
    chk("down2_s5", int'(cnt_s5), 0);
    chk("down2_s5_tc", int'(tc_s5), 1);
    up_dn = 1'b1;
    #1;
    chk("dirflip_s5_tc", int'(tc_s5), 0);
    tick();

    // Out-of-range load clamps to the top.
    lv4 = 4'd7; load = 1'b1; tick(); load = 1'b0;
    chk("load7_w5", int'(cnt_w5), 4);
    chk("load7_w10", int'(cnt_w10), 7);

    // Load coinciding with a step: step discarded.
    up_dn = 1'b1;
    step_raw = 1'b1;
    tick(); tick();
    lv4 = 4'd2; load = 1'b1; tick(); load = 1'b0;
    chk("load_vs_step_w5", int'(cnt_w5), 2);
    chk("load_vs_step_wrap", int'(wrap_w5), 0);
    step_raw = 1'b0;
    repeat (3) tick();

    // Clear coinciding with a step at count 3.
    lv4 = 4'd3; load = 1'b1; tick(); load = 1'b0;
    step_raw = 1'b1;
    tick(); tick();
    clear = 1'b1; tick(); clear = 1'b0;
    chk("clear_vs_step_w5", int'(cnt_w5), 0);
    step_raw = 1'b0;
    repeat (3) tick();

    // Asynchronous reset mid-cycle at count 2.
    lv4 = 4'd2; load = 1'b1; tick(); load = 1'b0;
    tick();
    #1 reset = 1'b1;
    #1;
    chk("async_rst_w5", int'(cnt_w5), 0);
    chk("async_rst_w10", int'(cnt_w10), 0);
    tick();
    reset = 1'b0;
    repeat (2) tick();

    // Eleven down steps from zero.
    clear = 1'b1; tick(); clear = 1'b0;
    repeat (11) step_pulse(1'b0);
    chk("down11_w10", int'(cnt_w10), 9);
    chk("down11_w5", int'(cnt_w5), 4);

    // Randomised traffic.
    repeat (500) begin
      step_raw = 1'($urandom_range(0, 1));
      clear    = ($urandom_range(0, 15) == 0);
      load     = ($urandom_range(0, 15) == 0);
      lv4      = 4'($urandom_range(0, 15));
      up_dn    = ($urandom_range(0, 3) != 0);
      reset    = ($urandom_range(0, 99) == 0);
      tick();
    end
    reset = 1'b0; clear = 1'b0; load = 1'b0; step_raw = 1'b0;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_mod_n_step_counter
